vga_bus_bridge: RTL and testbench

- Parametrised successor to the VGA CPU-bus interface: address-window decode, a posted-write FIFO, and a stalling read path toward the VGA framebuffer port.
- Sits between the CPU IO bus and the VGA adapter's framebuffer port.
- CPU writes are buffered so the CPU is not stalled by pixel-fetch contention.
- Reads drain pending writes first to preserve order, then stall the CPU until framebuffer data returns.
- Output read data is zero outside the window, so the top level OR-muxes slaves (no tri-states).

---
 rtl/vga_bus_bridge.sv | 167 ++++++++++++++++
 tb/tb_vga_bus_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bus_bridge.sv
// CPU-bus to VGA framebuffer bridge: window decode, posted-write FIFO, stalling reads.
// Optional read watchdog with sticky oBusErr when VGA_BUS_TIMEOUT_EN is defined.
module vga_bus_bridge #(
  parameter logic [31:0] BASE_ADDR       = 32'hFF00_0000,
  parameter int          SPAN_LOG2       = 17,
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter int          TIMEOUT_CYCLES  = 1024
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iBusRead,
  input  logic                       iBusWrite,
  input  logic [3:0]                 iBusByteEn,
  input  logic [31:0]                iBusAddr,
  input  logic [31:0]                iBusWData,
  output logic [31:0]                oBusRData,
  output logic                       oBusRValid,
  output logic                       oBusStall,
  output logic [SPAN_LOG2-3:0]       oFbAddr,
  output logic [31:0]                oFbWData,
  output logic [3:0]                 oFbByteEn,
  output logic                       oFbWrite,
  output logic                       oFbRead,
  input  logic                       iFbReady,
  input  logic [31:0]                iFbRData,
  input  logic                       iFbRValid,
  output logic [FIFO_DEPTH_LOG2:0]   oFifoLevel
`ifdef VGA_BUS_TIMEOUT_EN
  ,
  output logic                       oBusErr
`endif
);

  localparam int AW    = SPAN_LOG2 - 2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int EW    = AW + 36;

  typedef enum logic [2:0] {IDLE, DRAIN, RREQ, RWAIT, RDONE} stateT;

  stateT state, nextState;

  logic [31:0]            offset;
  logic                   hit;
  logic [AW-1:0]          busWordAddr;
  logic [EW-1:0]          fifoMem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wrPtr, rdPtr;
  logic                   fifoEmpty, fifoFull;
  logic [EW-1:0]          headEntry;
  logic                   writeReq, push, pop, readReq, drainActive;
  logic [AW-1:0]          rdAddrReg;
  logic [31:0]            rdDataReg;
  logic                   timeoutHit;

  // Underflow of the subtraction makes the shifted offset non-zero, so below-window misses too.
  assign offset      = iBusAddr - BASE_ADDR;
  assign hit         = (iBusAddr >= BASE_ADDR) && ((offset >> SPAN_LOG2) == 32'd0);
  assign busWordAddr = offset[SPAN_LOG2-1:2];

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[FIFO_DEPTH_LOG2] != rdPtr[FIFO_DEPTH_LOG2]) &&
                     (wrPtr[FIFO_DEPTH_LOG2-1:0] == rdPtr[FIFO_DEPTH_LOG2-1:0]);
  assign headEntry  = fifoMem[rdPtr[FIFO_DEPTH_LOG2-1:0]];
  assign oFifoLevel = wrPtr - rdPtr;

  assign writeReq    = (state == IDLE) && iBusWrite && hit && (iBusByteEn != 4'h0);
  assign push        = writeReq && !fifoFull;
  assign readReq     = (state == IDLE) && iBusRead && !iBusWrite && hit;
  assign drainActive = !fifoEmpty && (state != RREQ) && (state != RWAIT);
  assign pop         = drainActive && iFbReady && !iRST;

`ifdef VGA_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] toCount;

  // Counts cycles spent waiting on the framebuffer; the last counted cycle forces completion.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      toCount <= '0;
      oBusErr <= 1'b0;
    end else begin
      if ((state == RREQ) || (state == RWAIT)) toCount <= toCount + 1'b1;
      else                                     toCount <= '0;
      if (timeoutHit && !((state == RWAIT) && iFbRValid)) oBusErr <= 1'b1;
    end
  end

  assign timeoutHit = ((state == RREQ) || (state == RWAIT)) &&
                      (toCount == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (push && !iRST) fifoMem[wrPtr[FIFO_DEPTH_LOG2-1:0]] <= {busWordAddr, iBusWData, iBusByteEn};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      rdAddrReg <= '0;
      rdDataReg <= '0;
    end else begin
      state <= nextState;
      if (push)    wrPtr     <= wrPtr + 1'b1;
      if (pop)     rdPtr     <= rdPtr + 1'b1;
      if (readReq) rdAddrReg <= busWordAddr;
      if ((state == RWAIT) && iFbRValid) rdDataReg <= iFbRData;
      else if (timeoutHit)               rdDataReg <= 32'hDEAD_BEEF;
    end
  end

  always_comb begin
    nextState  = state;
    oBusStall  = 1'b0;
    oBusRValid = 1'b0;
    oBusRData  = 32'd0;
    oFbRead    = 1'b0;
    oFbWrite   = 1'b0;
    oFbAddr    = '0;
    oFbWData   = 32'd0;
    oFbByteEn  = 4'h0;
    case (state)
      IDLE: begin
        if (writeReq && fifoFull) begin
          oBusStall = 1'b1;
        end else if (readReq) begin
          oBusStall = 1'b1;
          nextState = fifoEmpty ? RREQ : DRAIN;
        end
      end
      DRAIN: begin
        oBusStall = 1'b1;
        if (fifoEmpty) nextState = RREQ;
      end
      RREQ: begin
        oBusStall = 1'b1;
        if (timeoutHit)    nextState = RDONE;
        else if (iFbReady) nextState = RWAIT;
      end
      RWAIT: begin
        oBusStall = 1'b1;
        if (iFbRValid || timeoutHit) nextState = RDONE;
      end
      RDONE: begin
        oBusRValid = 1'b1;
        oBusRData  = rdDataReg;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Framebuffer strobes are held off during reset; the address/data lanes read zero when idle.
    if (!iRST) begin
      if (state == RREQ) begin
        oFbRead = 1'b1;
        oFbAddr = rdAddrReg;
      end else if (drainActive) begin
        oFbWrite  = 1'b1;
        oFbAddr   = headEntry[EW-1:36];
        oFbWData  = headEntry[35:4];
        oFbByteEn = headEntry[3:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_bus_bridge.sv
// Bench for vga_bus_bridge: transaction-level model compared every cycle plus directed literal checks.
// The watchdog scenario runs only when VGA_BUS_TIMEOUT_EN is defined.
module tb_vga_bus_bridge;

  localparam logic [31:0] BASE  = 32'hFF00_0000;
  localparam int          SPAN  = 17;
  localparam int          DLOG  = 2;
  localparam int          DEPTH = 4;
  localparam int          TO    = 8;

  logic        iCLK, iRST;
  logic        iBusRead, iBusWrite;
  logic [3:0]  iBusByteEn;
  logic [31:0] iBusAddr, iBusWData;
  logic [31:0] oBusRData;
  logic        oBusRValid, oBusStall;
  logic [SPAN-3:0] oFbAddr;
  logic [31:0] oFbWData;
  logic [3:0]  oFbByteEn;
  logic        oFbWrite, oFbRead;
  logic        iFbReady;
  logic [31:0] iFbRData;
  logic        iFbRValid;
  logic [DLOG:0] oFifoLevel;
`ifdef VGA_BUS_TIMEOUT_EN
  logic        oBusErr;
`endif

  vga_bus_bridge #(
    .BASE_ADDR(BASE), .SPAN_LOG2(SPAN), .FIFO_DEPTH_LOG2(DLOG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iBusRead(iBusRead), .iBusWrite(iBusWrite), .iBusByteEn(iBusByteEn),
    .iBusAddr(iBusAddr), .iBusWData(iBusWData),
    .oBusRData(oBusRData), .oBusRValid(oBusRValid), .oBusStall(oBusStall),
    .oFbAddr(oFbAddr), .oFbWData(oFbWData), .oFbByteEn(oFbByteEn),
    .oFbWrite(oFbWrite), .oFbRead(oFbRead),
    .iFbReady(iFbReady), .iFbRData(iFbRData), .iFbRValid(iFbRValid),
    .oFifoLevel(oFifoLevel)
`ifdef VGA_BUS_TIMEOUT_EN
    , .oBusErr(oBusErr)
`endif
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit checkEn = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pending-write queue plus read progress flags.
  typedef struct { int addr; logic [31:0] data; logic [3:0] be; } wrT;
  wrT pend[$];
  bit rdBusy, reqOpen, reqAccepted, rdDone;
  int rdAddr;
  logic [31:0] rdResult;

  function automatic bit isHit(input logic [31:0] a);
    longint la;
    la = longint'({32'd0, a});
    return (la >= longint'({32'd0, BASE})) && (la < longint'({32'd0, BASE}) + (64'd1 << SPAN));
  endfunction

  function automatic int wordOf(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) >> 2;
    return int'(w);
  endfunction

  always @(posedge iCLK) begin
    int oldSize;
    wrT e;
    cyc++;
    oldSize = pend.size();
    if (iRST) begin
      pend.delete();
      rdBusy = 0; reqOpen = 0; reqAccepted = 0; rdDone = 0;
    end else begin
      if (oldSize > 0 && iFbReady) void'(pend.pop_front());
      if (rdDone) begin
        rdBusy = 0; rdDone = 0; reqOpen = 0; reqAccepted = 0;
      end else if (!rdBusy) begin
        if (iBusWrite) begin
          if (isHit(iBusAddr) && iBusByteEn != 4'h0 && oldSize < DEPTH) begin
            e.addr = wordOf(iBusAddr); e.data = iBusWData; e.be = iBusByteEn;
            pend.push_back(e);
          end
        end else if (iBusRead && isHit(iBusAddr)) begin
          rdBusy = 1;
          rdAddr = wordOf(iBusAddr);
          reqOpen = (oldSize == 0);
        end
      end else if (!reqOpen) begin
        reqOpen = (oldSize == 0);
      end else if (!reqAccepted) begin
        reqAccepted = iFbReady;
      end else if (iFbRValid) begin
        rdDone = 1;
        rdResult = iFbRData;
      end
    end
  end

  always @(negedge iCLK) begin
    bit expW, expR, expS;
    logic [31:0] expA, expD;
    logic [3:0] expB;
    if (checkEn) begin
      expW = !iRST && pend.size() > 0;
      expR = !iRST && reqOpen && !reqAccepted;
      expA = 0; expD = 0; expB = 0;
      if (expW) begin expA = pend[0].addr; expD = pend[0].data; expB = pend[0].be; end
      else if (expR) expA = rdAddr;
      if (rdBusy) expS = !rdDone;
      else if (iBusWrite) expS = isHit(iBusAddr) && iBusByteEn != 4'h0 && pend.size() == DEPTH;
      else expS = iBusRead && isHit(iBusAddr);
      checkOutput("fbWrite", 32'(oFbWrite), 32'(expW));
      checkOutput("fbRead", 32'(oFbRead), 32'(expR));
      checkOutput("fbExclusive", 32'(oFbRead & oFbWrite), 32'd0);
      checkOutput("fbAddr", 32'(oFbAddr), expA);
      checkOutput("fbWData", oFbWData, expD);
      checkOutput("fbByteEn", 32'(oFbByteEn), 32'(expB));
      checkOutput("busStall", 32'(oBusStall), 32'(expS));
      checkOutput("busRValid", 32'(oBusRValid), 32'(rdDone));
      checkOutput("busRData", oBusRData, rdDone ? rdResult : 32'd0);
      checkOutput("fifoLevel", 32'(oFifoLevel), 32'(pend.size()));
    end
  end

  // Framebuffer responder: memory, write log, read data one cycle after request acceptance.
  logic [31:0] fbMem [int];
  logic [31:0] wrLog[$];
  int wrCount = 0, rdCount = 0, lastWrCycle = 0, lastRdCycle = 0;
  bit respDue = 0, autoResp = 1, pokeRValid = 0;
  int respAddr = 0;

  always @(negedge iCLK) begin
    logic [31:0] v;
    if (oFbWrite && iFbReady) begin
      v = fbMem.exists(int'(oFbAddr)) ? fbMem[int'(oFbAddr)] : 32'd0;
      for (int b = 0; b < 4; b++) if (oFbByteEn[b]) v[8*b +: 8] = oFbWData[8*b +: 8];
      fbMem[int'(oFbAddr)] = v;
      wrLog.push_back(oFbWData);
      wrCount++;
      lastWrCycle = cyc;
    end
    if (oFbRead && iFbReady) begin
      respDue = autoResp;
      respAddr = int'(oFbAddr);
      rdCount++;
      lastRdCycle = cyc;
    end else begin
      respDue = 0;
    end
  end

  always @(posedge iCLK) begin
    #2;
    iFbRValid = respDue || pokeRValid;
    if (respDue)         iFbRData = fbMem.exists(respAddr) ? fbMem[respAddr] : 32'd0;
    else if (pokeRValid) iFbRData = 32'hBAD0_BAD0;
    else                 iFbRData = 32'd0;
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] data);
    iBusRead = rd; iBusWrite = wr; iBusByteEn = be; iBusAddr = addr; iBusWData = data;
  endtask

  task automatic stepCycle;
    @(posedge iCLK); #1;
  endtask

  // Holds a request until stall drops; returns at that negedge with stalled-cycle count.
  task automatic doOp(input logic rd, input logic wr, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] data, output int sc);
    int n;
    applyStimulus(rd, wr, be, addr, data);
    sc = 0; n = 0;
    @(negedge iCLK);
    while (oBusStall && n < 200) begin
      sc++; n++;
      @(posedge iCLK); #1;
      @(negedge iCLK);
    end
    if (n >= 200) checkOutput("opStallBound", 32'(oBusStall), 32'd0);
  endtask

  task automatic endOp;
    stepCycle();
    applyStimulus(0, 0, 4'h0, 32'd0, 32'd0);
  endtask

  task automatic waitDrained;
    int n;
    n = 0;
    @(negedge iCLK);
    while (oFifoLevel != 0 && n < 100) begin
      stepCycle();
      @(negedge iCLK);
      n++;
    end
    checkOutput("drainDone", 32'(oFifoLevel), 32'd0);
    stepCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc, wb, rb;
    iRST = 1; iFbReady = 1;
    applyStimulus(0, 0, 4'h0, 32'd0, 32'd0);
    fbMem[2] = 32'hCAFE_F00D;
    repeat (2) @(posedge iCLK);
    #1 iRST = 0;
    @(negedge iCLK);
    checkEn = 1;
    checkOutput("rstStall", 32'(oBusStall), 32'd0);
    checkOutput("rstRValid", 32'(oBusRValid), 32'd0);
    checkOutput("rstFbWrite", 32'(oFbWrite), 32'd0);
    checkOutput("rstLevel", 32'(oFifoLevel), 32'd0);
    stepCycle();

    $display("[TB] single posted write");
    doOp(0, 1, 4'hF, 32'hFF00_0010, 32'h1122_3344, sc);
    checkOutput("t1Stall", 32'(oBusStall), 32'd0);
    endOp();
    @(negedge iCLK);
    checkOutput("t1FbWrite", 32'(oFbWrite), 32'd1);
    checkOutput("t1FbAddr", 32'(oFbAddr), 32'd4);
    checkOutput("t1FbWData", oFbWData, 32'h1122_3344);
    stepCycle();

    $display("[TB] zero byte-enable write");
    doOp(0, 1, 4'h0, 32'hFF00_0040, 32'h5555_5555, sc);
    checkOutput("be0Stall", 32'(oBusStall), 32'd0);
    endOp();
    @(negedge iCLK);
    checkOutput("be0Level", 32'(oFifoLevel), 32'd0);
    stepCycle();

    $display("[TB] fill FIFO with ready low");
    iFbReady = 0;
    wrLog.delete();
    for (int i = 0; i < 4; i++) begin
      doOp(0, 1, 4'hF, 32'hFF00_0100 + 32'(4*i), 32'hA0A0_0000 + 32'(i), sc);
      endOp();
    end
    applyStimulus(0, 1, 4'hF, 32'hFF00_0110, 32'hA0A0_0004);
    @(negedge iCLK);
    checkOutput("fullLevel", 32'(oFifoLevel), 32'd4);
    checkOutput("fullStall", 32'(oBusStall), 32'd1);
    stepCycle();
    stepCycle();
    iFbReady = 1;
    doOp(0, 1, 4'hF, 32'hFF00_0110, 32'hA0A0_0004, sc);
    endOp();
    waitDrained();
    checkOutput("orderCount", 32'(wrLog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput("orderData", (i < wrLog.size()) ? wrLog[i] : 32'hX, 32'hA0A0_0000 + 32'(i));

    $display("[TB] best-case read");
    doOp(1, 0, 4'h0, 32'hFF00_0008, 32'd0, sc);
    checkOutput("rdStallCycles", 32'(sc), 32'd3);
    checkOutput("rdValid", 32'(oBusRValid), 32'd1);
    checkOutput("rdData", oBusRData, 32'hCAFE_F00D);
    endOp();

    $display("[TB] writes then read same word");
    wb = wrCount; rb = rdCount;
    doOp(0, 1, 4'hF, 32'hFF00_0020, 32'hAAAA_AAAA, sc); endOp();
    doOp(0, 1, 4'h1, 32'hFF00_0022, 32'h0000_00BB, sc); endOp();
    doOp(1, 0, 4'h0, 32'hFF00_0020, 32'd0, sc);
    checkOutput("rawValid", 32'(oBusRValid), 32'd1);
    checkOutput("rawData", oBusRData, 32'hAAAA_AABB);
    endOp();
    checkOutput("rawWrites", 32'(wrCount - wb), 32'd2);
    checkOutput("rawReads", 32'(rdCount - rb), 32'd1);
    checkOutput("rawOrder", 32'(lastRdCycle > lastWrCycle), 32'd1);

    $display("[TB] read miss");
    wb = wrCount; rb = rdCount;
    doOp(1, 0, 4'h0, 32'h0000_1000, 32'd0, sc);
    checkOutput("missStall", 32'(oBusStall), 32'd0);
    checkOutput("missRData", oBusRData, 32'd0);
    checkOutput("missRValid", 32'(oBusRValid), 32'd0);
    endOp();
    repeat (2) stepCycle();
    checkOutput("missFbActivity", 32'((wrCount - wb) + (rdCount - rb)), 32'd0);

    $display("[TB] reset during read wait");
    autoResp = 0;
    applyStimulus(1, 0, 4'h0, 32'hFF00_000C, 32'd0);
    stepCycle();
    stepCycle();
    iRST = 1;
    applyStimulus(0, 0, 4'h0, 32'd0, 32'd0);
    stepCycle();
    iRST = 0;
    pokeRValid = 1;
    @(negedge iCLK);
    checkOutput("abortStall", 32'(oBusStall), 32'd0);
    checkOutput("abortRValid", 32'(oBusRValid), 32'd0);
    checkOutput("abortFbRead", 32'(oFbRead), 32'd0);
    checkOutput("abortLevel", 32'(oFifoLevel), 32'd0);
    stepCycle();
    pokeRValid = 0;
    @(negedge iCLK);
    checkOutput("abortLateRValid", 32'(oBusRValid), 32'd0);
    stepCycle();
    repeat (3) stepCycle();
    autoResp = 1;

`ifdef VGA_BUS_TIMEOUT_EN
    $display("[TB] read watchdog");
    checkEn = 0;
    autoResp = 0;
    doOp(1, 0, 4'h0, 32'hFF00_0004, 32'd0, sc);
    checkOutput("toStallCycles", 32'(sc), 32'(TO + 1));
    checkOutput("toRValid", 32'(oBusRValid), 32'd1);
    checkOutput("toRData", oBusRData, 32'hDEAD_BEEF);
    endOp();
    repeat (2) stepCycle();
    checkOutput("toErrSticky", 32'(oBusErr), 32'd1);
    iRST = 1;
    stepCycle();
    iRST = 0;
    @(negedge iCLK);
    checkOutput("toErrCleared", 32'(oBusErr), 32'd0);
    stepCycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
